// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the frogger game-control slice:
//               external game-state codes (shared with the game FSM),
//               the internal encoding of the lives/collision tracker
//               and the lives counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Game states driven by the game-state FSM
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] WIN   = 2'b10;
  localparam logic [1:0] CLEAN = 2'b11;

  // Internal tracker states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_HIT     = 2'd2;
  localparam logic [1:0] S_RESPAWN = 2'd3;

  localparam int LIVES_W = 4;

  // Width of a down-counter that must hold values 0 .. n-1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_hit_detector.sv
`default_nettype none
// ============================================================================
// Module      : car_hit_detector
// Description : Registered frog/car overlap detector. Each car occupies
//               columns car_x .. car_x+CAR_LEN-1 on its row; hit_q is the
//               OR of all per-car overlaps, one cycle after the inputs.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               frog_x, frog_y   - frog grid position
//               car_x, car_y     - packed car positions, car 0 in LSBs
//               hit_q            - registered overlap flag
// Revision    : 1.0 - initial release
// ============================================================================
module car_hit_detector #(
  parameter int N_CARS  = 4,
  parameter int COL_W   = 5,
  parameter int ROW_W   = 4,
  parameter int CAR_LEN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COL_W-1:0]          frog_x,
  input  logic [ROW_W-1:0]          frog_y,
  input  logic [N_CARS*COL_W-1:0]   car_x,
  input  logic [N_CARS*ROW_W-1:0]   car_y,
  output logic                      hit_q
);

  localparam logic [COL_W:0] SPAN = (COL_W+1)'(CAR_LEN - 1);

  logic [N_CARS-1:0] overlap;

  generate
    for (genvar i = 0; i < N_CARS; i++) begin : g_car
      logic [COL_W-1:0] cx;
      logic [ROW_W-1:0] cy;
      logic [COL_W:0]   cx_hi;

      assign cx = car_x[i*COL_W +: COL_W];
      assign cy = car_y[i*ROW_W +: ROW_W];
      // One extra bit so a car near the right edge cannot wrap to column 0
      assign cx_hi = {1'b0, cx} + SPAN;

      assign overlap[i] = (cy == frog_y) &&
                          (frog_x >= cx) &&
                          ({1'b0, frog_x} <= cx_hi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= |overlap;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lives_collision_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lives_collision_tracker
// Description : Detects frog/car collisions, owns the lives counter and
//               drives the collision/clean handshake towards the game FSM:
//               collision is held through CLEAN, a one-cycle respawn pulse
//               is sent to the frog controller, and collision is released
//               RESPAWN_CYCLES+1 cycles after CLEAN is first seen.
// Ports       : i_Clk, i_Reset_n   - clock, synchronous active-low reset
//               i_Game_State       - 00 IDLE, 01 RUN, 10 WIN, 11 CLEAN
//               i_Frog_X/i_Frog_Y  - frog grid position
//               i_Car_X/i_Car_Y    - packed car positions, car 0 in LSBs
//               o_Collision        - collision flag to the FSM
//               o_Lives            - remaining lives
//               o_Win_Condition    - win flag to the FSM
//               o_Respawn          - one-cycle frog respawn pulse
// Options     : GRACE_PERIOD_EN    - when defined, hits are ignored for
//                                    GRACE_CYCLES-1 cycles after a respawn
// Revision    : 1.0 - initial release
// ============================================================================
module lives_collision_tracker
  import game_pkg::*;
#(
  parameter int N_CARS         = 4,
  parameter int COL_W          = 5,
  parameter int ROW_W          = 4,
  parameter int CAR_LEN        = 3,
  parameter int INIT_LIVES     = 3,
  parameter int WIN_ROW        = 0,
  parameter int RESPAWN_CYCLES = 16,
  parameter int GRACE_CYCLES   = 64
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset_n,
  input  logic [1:0]                i_Game_State,
  input  logic [COL_W-1:0]          i_Frog_X,
  input  logic [ROW_W-1:0]          i_Frog_Y,
  input  logic [N_CARS*COL_W-1:0]   i_Car_X,
  input  logic [N_CARS*ROW_W-1:0]   i_Car_Y,
  output logic                      o_Collision,
  output logic [LIVES_W-1:0]        o_Lives,
  output logic                      o_Win_Condition,
  output logic                      o_Respawn
);

  localparam int                 CNT_W      = cnt_width(RESPAWN_CYCLES);
  localparam logic [CNT_W-1:0]   RESP_LOAD  = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [ROW_W-1:0]   WIN_ROW_V  = ROW_W'(WIN_ROW);

  logic                 hit_q;
  logic                 hit_live;
  logic                 release_now;
  logic [1:0]           state;
  logic [CNT_W-1:0]     resp_cnt;
  logic [LIVES_W-1:0]   lives;
  logic                 collision;
  logic                 win;
  logic                 respawn;

  car_hit_detector #(
    .N_CARS  (N_CARS),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W),
    .CAR_LEN (CAR_LEN)
  ) u_hit (
    .clk    (i_Clk),
    .rst_n  (i_Reset_n),
    .frog_x (i_Frog_X),
    .frog_y (i_Frog_Y),
    .car_x  (i_Car_X),
    .car_y  (i_Car_Y),
    .hit_q  (hit_q)
  );

  // WIN freezes the respawn countdown; IDLE is handled before the FSM
  assign release_now = (state == S_RESPAWN) &&
                       ((i_Game_State == RUN) || (i_Game_State == CLEAN)) &&
                       (resp_cnt == '0);

`ifdef GRACE_PERIOD_EN
  localparam int               GR_W    = cnt_width(GRACE_CYCLES);
  localparam logic [GR_W-1:0]  GR_LOAD = GR_W'(GRACE_CYCLES - 1);

  logic [GR_W-1:0] grace_cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n || (i_Game_State == IDLE)) begin
      grace_cnt <= '0;
    end else if (release_now) begin
      grace_cnt <= GR_LOAD;
    end else if (grace_cnt != '0) begin
      grace_cnt <= grace_cnt - GR_W'(1);
    end
  end

  assign hit_live = hit_q && (grace_cnt == '0);
`else
  assign hit_live = hit_q;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state     <= S_IDLE;
      lives     <= LIVES_INIT;
      collision <= 1'b0;
      win       <= 1'b0;
      respawn   <= 1'b0;
      resp_cnt  <= '0;
    end else begin
      respawn <= 1'b0;
      if (i_Game_State == IDLE) begin
        state     <= S_IDLE;
        lives     <= LIVES_INIT;
        collision <= 1'b0;
        win       <= 1'b0;
        resp_cnt  <= '0;
      end else if (i_Game_State == WIN) begin
        // Lives, win level and tracker state are frozen
        collision <= 1'b0;
      end else begin
        if (i_Game_State == CLEAN) begin
          win <= 1'b0;
        end
        case (state)
          S_IDLE: begin
            if (i_Game_State == RUN) begin
              state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (i_Game_State == RUN) begin
              if (hit_live) begin
                // A hit beats a simultaneous arrival on the win row
                win <= 1'b0;
                if (lives > LIVES_ONE) begin
                  lives     <= lives - LIVES_ONE;
                  collision <= 1'b1;
                  state     <= S_HIT;
                end else begin
                  // Last life lost: no handshake, the FSM goes to IDLE
                  lives <= '0;
                end
              end else if (i_Frog_Y == WIN_ROW_V) begin
                win <= 1'b1;
              end
            end
          end
          S_HIT: begin
            if (i_Game_State == CLEAN) begin
              respawn  <= 1'b1;
              resp_cnt <= RESP_LOAD;
              state    <= S_RESPAWN;
            end
          end
          S_RESPAWN: begin
            if (release_now) begin
              collision <= 1'b0;
              state     <= S_PLAY;
            end else begin
              resp_cnt <= resp_cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Collision     = collision;
  assign o_Lives         = lives;
  assign o_Win_Condition = win;
  assign o_Respawn       = respawn;

endmodule
`default_nettype wire

// File: tb/tb_lives_collision_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lives_collision_tracker
// Description : Self-checking bench for lives_collision_tracker. A vector
//               table and directed sequences cover the handshake corners;
//               random traffic is compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lives_collision_tracker;

  localparam int N_CARS = 4;
  localparam int COL_W = 5;
  localparam int ROW_W = 4;
  localparam int CAR_LEN = 3;
  localparam int INIT_LIVES = 3;
  localparam int WIN_ROW = 0;
  localparam int RESPAWN_CYCLES = 16;
  localparam int GRACE_CYCLES = 64;

  localparam logic [1:0] G_IDLE = 2'b00, G_RUN = 2'b01, G_WIN = 2'b10, G_CLEAN = 2'b11;
  localparam int P_IDLE = 0, P_PLAY = 1, P_HIT = 2, P_RESP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] gs = G_IDLE;
  int frog_x = 0;
  int frog_y = 0;
  int car_x_a[N_CARS];
  int car_y_a[N_CARS];

  logic [N_CARS*COL_W-1:0] car_x_p;
  logic [N_CARS*ROW_W-1:0] car_y_p;
  logic o_coll, o_win, o_resp;
  logic [3:0] o_lives;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Behavioural model state
  int m_lives, m_phase, m_left;
  bit m_coll, m_win, m_resp, m_hit;

  always #5 clk = ~clk;

  always_comb begin
    car_x_p = '0;
    car_y_p = '0;
    for (int i = 0; i < N_CARS; i++) begin
      car_x_p[i*COL_W +: COL_W] = COL_W'(car_x_a[i]);
      car_y_p[i*ROW_W +: ROW_W] = ROW_W'(car_y_a[i]);
    end
  end

  lives_collision_tracker #(
    .N_CARS(N_CARS), .COL_W(COL_W), .ROW_W(ROW_W), .CAR_LEN(CAR_LEN),
    .INIT_LIVES(INIT_LIVES), .WIN_ROW(WIN_ROW),
    .RESPAWN_CYCLES(RESPAWN_CYCLES), .GRACE_CYCLES(GRACE_CYCLES)
  ) dut (
    .i_Clk(clk),
    .i_Reset_n(rst_n),
    .i_Game_State(gs),
    .i_Frog_X(COL_W'(frog_x)),
    .i_Frog_Y(ROW_W'(frog_y)),
    .i_Car_X(car_x_p),
    .i_Car_Y(car_y_p),
    .o_Collision(o_coll),
    .o_Lives(o_lives),
    .o_Win_Condition(o_win),
    .o_Respawn(o_resp)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Game rules applied to the inputs present at the coming clock edge
  task automatic model_step();
    bit ov;
    bit old;
    ov = 1'b0;
    for (int i = 0; i < N_CARS; i++)
      if (car_y_a[i] == frog_y && frog_x >= car_x_a[i] && frog_x <= car_x_a[i] + CAR_LEN - 1)
        ov = 1'b1;
    if (!rst_n) begin
      m_lives = INIT_LIVES; m_coll = 0; m_win = 0; m_resp = 0; m_hit = 0;
      m_phase = P_IDLE; m_left = 0;
      return;
    end
    old = m_hit;
    m_hit = ov;
    m_resp = 0;
    if (gs == G_IDLE) begin
      m_phase = P_IDLE; m_lives = INIT_LIVES; m_coll = 0; m_win = 0;
    end else if (gs == G_WIN) begin
      m_coll = 0;
    end else begin
      if (gs == G_CLEAN) m_win = 0;
      if (m_phase == P_IDLE) begin
        if (gs == G_RUN) m_phase = P_PLAY;
      end else if (m_phase == P_PLAY) begin
        if (gs == G_RUN) begin
          if (old) begin
            m_win = 0;
            if (m_lives > 1) begin
              m_lives = m_lives - 1; m_coll = 1; m_phase = P_HIT;
            end else begin
              m_lives = 0;
            end
          end else if (frog_y == WIN_ROW) begin
            m_win = 1;
          end
        end
      end else if (m_phase == P_HIT) begin
        if (gs == G_CLEAN) begin
          m_resp = 1; m_left = RESPAWN_CYCLES; m_phase = P_RESP;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_coll = 0; m_phase = P_PLAY;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("model_collision", int'(o_coll), int'(m_coll));
    chk("model_lives", int'(o_lives), m_lives);
    chk("model_win", int'(o_win), int'(m_win));
    chk("model_respawn", int'(o_resp), int'(m_resp));
  endtask

  task automatic drive(input logic r, input logic [1:0] g, input int fx, input int fy,
                       input int cx, input int cy);
    rst_n = r; gs = g; frog_x = fx; frog_y = fy;
    car_x_a[0] = cx; car_y_a[0] = cy;
  endtask

  typedef struct {
    logic rst_n; logic [1:0] gs; int fx; int fy; int cx; int cy;
    int coll; int lives; int win; int resp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    for (int i = 0; i < N_CARS; i++) begin
      car_x_a[i] = 0;
      car_y_a[i] = 15;
    end
    m_lives = INIT_LIVES; m_phase = P_IDLE; m_left = 0;
    m_coll = 0; m_win = 0; m_resp = 0; m_hit = 0;

    tbl[0] = '{1'b0, G_IDLE,  10, 5, 20, 9, 0, 3, 0, 0};
    tbl[1] = '{1'b1, G_RUN,   10, 5,  9, 5, 0, 3, 0, 0};
    tbl[2] = '{1'b1, G_RUN,   10, 5,  9, 5, 1, 2, 0, 0};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b1, G_RUN, 10, 5, 9, 5, 1, 2, 0, 0};
    tbl[8] = '{1'b1, G_CLEAN, 10, 5, 20, 9, 1, 2, 0, 1};

    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst_n, tbl[i].gs, tbl[i].fx, tbl[i].fy, tbl[i].cx, tbl[i].cy);
      tick();
      chk($sformatf("tbl%0d_collision", i), int'(o_coll), tbl[i].coll);
      chk($sformatf("tbl%0d_lives", i), int'(o_lives), tbl[i].lives);
      chk($sformatf("tbl%0d_win", i), int'(o_win), tbl[i].win);
      chk($sformatf("tbl%0d_respawn", i), int'(o_resp), tbl[i].resp);
    end

    // Collision held for the rest of the respawn window, released on edge 17
    for (int k = 1; k <= RESPAWN_CYCLES - 1; k++) begin
      tick();
      chk("respawn_hold_collision", int'(o_coll), 1);
      chk("respawn_single_pulse", int'(o_resp), 0);
    end
    tick();
    chk("respawn_release_collision", int'(o_coll), 0);
    chk("respawn_release_lives", int'(o_lives), 2);

    // Second hit takes lives to 1, then clean up
    drive(1, G_RUN, 10, 5, 9, 5);
    tick();
    chk("hit2_latency", int'(o_coll), 0);
    tick();
    chk("hit2_collision", int'(o_coll), 1);
    chk("hit2_lives", int'(o_lives), 1);
    drive(1, G_CLEAN, 10, 5, 20, 9);
    for (int k = 0; k <= RESPAWN_CYCLES; k++) tick();
    chk("hit2_release", int'(o_coll), 0);

    // Last life: lives go to 0 with no collision, saturate, IDLE reloads
    drive(1, G_RUN, 10, 5, 9, 5);
    tick();
    tick();
    chk("last_life_lives", int'(o_lives), 0);
    chk("last_life_no_collision", int'(o_coll), 0);
    tick();
    chk("lives_saturate", int'(o_lives), 0);
    drive(1, G_IDLE, 10, 5, 9, 5);
    tick();
    chk("idle_reload_lives", int'(o_lives), 3);

    // Hit and win row at the same time: hit wins
    drive(1, G_RUN, 4, 0, 3, 0);
    tick();
    tick();
    chk("hit_vs_win_collision", int'(o_coll), 1);
    chk("hit_vs_win_win", int'(o_win), 0);
    drive(1, G_IDLE, 4, 0, 20, 9);
    tick();
    drive(1, G_RUN, 4, 0, 20, 9);
    tick();
    tick();
    chk("win_set", int'(o_win), 1);
    drive(1, G_WIN, 4, 0, 20, 9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("win_held", int'(o_win), 1);
      chk("win_lives_frozen", int'(o_lives), 3);
    end
    drive(1, G_IDLE, 4, 0, 20, 9);
    tick();
    chk("idle_clears_win", int'(o_win), 0);

    // Right-edge car must not wrap to column 0
    drive(1, G_RUN, 0, 5, 30, 5);
    tick(); tick(); tick();
    chk("no_wrap_collision", int'(o_coll), 0);
    chk("no_wrap_lives", int'(o_lives), 3);
    drive(1, G_IDLE, 0, 5, 30, 5);
    tick();
    drive(1, G_RUN, 31, 5, 29, 5);
    tick(); tick();
    chk("right_edge_hit", int'(o_coll), 1);
    chk("right_edge_lives", int'(o_lives), 2);

    // Reset in the middle of the respawn countdown
    drive(1, G_CLEAN, 31, 5, 20, 9);
    tick();
    chk("mid_resp_pulse", int'(o_resp), 1);
    for (int k = 0; k < 7; k++) tick();
    drive(0, G_CLEAN, 31, 5, 20, 9);
    tick();
    chk("rst_collision", int'(o_coll), 0);
    chk("rst_lives", int'(o_lives), 3);
    chk("rst_win", int'(o_win), 0);
    chk("rst_respawn", int'(o_resp), 0);
    drive(1, G_CLEAN, 31, 5, 20, 9);
    tick();
    chk("rst_no_late_pulse", int'(o_resp), 0);

    // Random traffic against the model
    drive(0, G_IDLE, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      rst_n = ($urandom_range(0, 199) != 0);
      gs = (r < 3) ? G_IDLE : (r < 75) ? G_RUN : (r < 82) ? G_WIN : G_CLEAN;
      frog_x = $urandom_range(0, 31);
      frog_y = $urandom_range(0, 3);
      for (int i = 0; i < N_CARS; i++) begin
        car_x_a[i] = $urandom_range(0, 31);
        car_y_a[i] = $urandom_range(0, 3);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
